// File: rtl/arya_cpu_pkg.sv
// ============================================================================
// Module      : arya_cpu_pkg
// Description : Shared types and constants for the multi-lane job engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arya_cpu_pkg;

  localparam int PERF_CNT_W = 32;

  // Default field widths of a job record (match the engine's default parameters).
  localparam int JOB_ID_W  = 4;
  localparam int JOB_CYC_W = 8;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_RUN  = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_e;

  typedef struct packed {
    logic [JOB_ID_W-1:0]  id;
    logic [JOB_CYC_W-1:0] cycles;
  } job_t;

endpackage : arya_cpu_pkg

`default_nettype wire

// File: rtl/cpu_job_engine_lane.sv
// ============================================================================
// Module      : cpu_lane
// Description : One processor lane: IDLE/RUN/DONE state machine, run-length
//               down-counter and job tag latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_lane
  import arya_cpu_pkg::*;
#(
  parameter int CYC_W = 8,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CYC_W-1:0] cycles_i,
  input  logic [ID_W-1:0]  id_i,
  input  logic             grant_i,
  output lane_state_e      state_o,
  output logic [ID_W-1:0]  id_o
);

  lane_state_e      state_q, state_d;
  logic [CYC_W-1:0] cnt_q,   cnt_d;
  logic [ID_W-1:0]  id_q,    id_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LANE_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    case (state_q)
      LANE_IDLE: begin
        if (start_i) begin
          state_d = LANE_RUN;
          // A zero run length behaves as a single-cycle job.
          cnt_d   = (cycles_i == '0) ? CYC_W'(1) : cycles_i;
          id_d    = id_i;
        end
      end
      LANE_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CYC_W'(1)) begin
          state_d = LANE_DONE;
        end
      end
      LANE_DONE: begin
        if (grant_i) begin
          state_d = LANE_IDLE;
        end
      end
      default: begin
        state_d = LANE_IDLE;
      end
    endcase
  end

  assign state_o = state_q;
  assign id_o    = id_q;

endmodule : cpu_lane

`default_nettype wire

// File: rtl/cpu_job_engine.sv
// ============================================================================
// Module      : cpu_job_engine
// Description : NUM_LANES job lanes with lowest-index dispatch and a registered
//               round-robin completion output. Macro ARYA_PERF_CNT_EN adds the
//               32-bit jobs_done_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_job_engine
  import arya_cpu_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CYC_W     = 8,
  parameter int ID_W      = 4,
  localparam int LANE_W   = $clog2(NUM_LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [CYC_W-1:0]      job_cycles,
  input  logic [ID_W-1:0]       job_id,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [ID_W-1:0]       done_id,
  output logic [LANE_W-1:0]     done_lane,
  output logic [NUM_LANES-1:0]  busy,
  output logic                  all_idle
`ifdef ARYA_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] jobs_done_cnt
`endif
);

  lane_state_e          lane_state [NUM_LANES];
  logic [ID_W-1:0]      lane_id    [NUM_LANES];
  logic [NUM_LANES-1:0] lane_idle;
  logic [NUM_LANES-1:0] lane_done;
  logic [NUM_LANES-1:0] lane_start;
  logic [NUM_LANES-1:0] lane_grant;

  logic                 disp_found;
  logic                 arb_hit;
  logic [LANE_W-1:0]    grant_idx;
  logic [LANE_W-1:0]    scan_idx;
  logic                 out_load;

  logic                 done_valid_q, done_valid_d;
  logic [ID_W-1:0]      done_id_q,    done_id_d;
  logic [LANE_W-1:0]    done_lane_q,  done_lane_d;
  logic [LANE_W-1:0]    rr_ptr_q,     rr_ptr_d;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cpu_lane #(
      .CYC_W (CYC_W),
      .ID_W  (ID_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .start_i  (lane_start[g]),
      .cycles_i (job_cycles),
      .id_i     (job_id),
      .grant_i  (lane_grant[g]),
      .state_o  (lane_state[g]),
      .id_o     (lane_id[g])
    );

    assign lane_idle[g] = (lane_state[g] == LANE_IDLE);
    assign lane_done[g] = (lane_state[g] == LANE_DONE);
  end

  // Dispatch looks only at registered lane state, so a lane released this
  // cycle becomes eligible on the next one.
  always_comb begin
    lane_start = '0;
    disp_found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!disp_found && lane_idle[i]) begin
        lane_start[i] = job_valid;
        disp_found    = 1'b1;
      end
    end
  end

  assign job_ready = |lane_idle;
  assign out_load  = !done_valid_q || done_ready;

  always_comb begin
    arb_hit    = 1'b0;
    grant_idx  = '0;
    scan_idx   = '0;
    lane_grant = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      scan_idx = LANE_W'((int'(rr_ptr_q) + i) % NUM_LANES);
      if (!arb_hit && lane_done[scan_idx]) begin
        arb_hit   = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (out_load && arb_hit) begin
      lane_grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    done_valid_d = done_valid_q;
    done_id_d    = done_id_q;
    done_lane_d  = done_lane_q;
    rr_ptr_d     = rr_ptr_q;
    if (out_load) begin
      done_valid_d = arb_hit;
      if (arb_hit) begin
        done_id_d   = lane_id[grant_idx];
        done_lane_d = grant_idx;
        rr_ptr_d    = (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_lane_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_lane_q  <= done_lane_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;
  assign done_lane  = done_lane_q;
  assign busy       = ~lane_idle;
  assign all_idle   = (&lane_idle) && !done_valid_q;

`ifdef ARYA_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt_q <= '0;
    end else if (done_valid_q && done_ready) begin
      perf_cnt_q <= perf_cnt_q + 1'b1;
    end
  end

  assign jobs_done_cnt = perf_cnt_q;
`endif

endmodule : cpu_job_engine

`default_nettype wire

// File: tb/tb_cpu_job_engine.sv
// ============================================================================
// Module      : tb_cpu_job_engine
// Description : Directed self-checking bench for cpu_job_engine (4 lanes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_job_engine;
  import arya_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_cycles;
  logic [3:0]  job_id;
  logic        done_valid;
  logic        done_ready;
  logic [3:0]  done_id;
  logic [1:0]  done_lane;
  logic [3:0]  busy;
  logic        all_idle;
`ifdef ARYA_PERF_CNT_EN
  logic [31:0] jobs_done_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cpu_job_engine #(
    .NUM_LANES (4),
    .CYC_W     (8),
    .ID_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_cycles (job_cycles),
    .job_id     (job_id),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_id    (done_id),
    .done_lane  (done_lane),
    .busy       (busy),
    .all_idle   (all_idle)
`ifdef ARYA_PERF_CNT_EN
    ,
    .jobs_done_cnt (jobs_done_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    job_valid = 1'b0;
    step();
    step();
    reset     = 1'b0;
  endtask

  // Offers one job for exactly one edge.
  task automatic send(input job_t j);
    job_valid  = 1'b1;
    job_id     = j.id;
    job_cycles = j.cycles;
    step();
    job_valid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid got %0h want 0", done_valid); end
    checks++; if (done_id !== 4'h0) begin errors++; $display("FAIL reset_done_id got %0h want 0", done_id); end
    checks++; if (done_lane !== 2'd0) begin errors++; $display("FAIL reset_done_lane got %0h want 0", done_lane); end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
    checks++; if (all_idle !== 1'b1) begin errors++; $display("FAIL reset_all_idle got %0h want 1", all_idle); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got %0h want 1", job_ready); end
  endtask

  task automatic test_single();
    do_reset();
    done_ready = 1'b1;
    send('{id: 4'd5, cycles: 8'd3});                     // edge 0
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL single_busy got %0h want 1", busy); end
    repeat (3) step();                                   // edge 3
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0h want 0", done_valid); end
    step();                                              // edge 4
    checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h want 1", done_valid); end
    checks++; if (done_id !== 4'd5) begin errors++; $display("FAIL single_id got %0h want 5", done_id); end
    checks++; if (done_lane !== 2'd0) begin errors++; $display("FAIL single_lane got %0h want 0", done_lane); end
    step();                                              // edge 5
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %0h want 0", done_valid); end
    checks++; if (all_idle !== 1'b1) begin errors++; $display("FAIL single_all_idle got %0h want 1", all_idle); end
  endtask

  task automatic test_zero_cycles();
    do_reset();
    done_ready = 1'b1;
    send('{id: 4'd2, cycles: 8'd0});                     // edge 0
    step();                                              // edge 1
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL zero_early got %0h want 0", done_valid); end
    step();                                              // edge 2
    checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0h want 1", done_valid); end
    checks++; if (done_id !== 4'd2) begin errors++; $display("FAIL zero_id got %0h want 2", done_id); end
    step();
  endtask

  task automatic test_full();
    do_reset();
    done_ready = 1'b1;
    for (int i = 0; i < 4; i++) send('{id: 4'(i + 1), cycles: 8'd10});   // edges 0..3
    checks++; if (busy !== 4'hF) begin errors++; $display("FAIL full_busy got %0h want f", busy); end
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0h want 0", job_ready); end
    job_valid  = 1'b1;
    job_id     = 4'd9;
    job_cycles = 8'd2;
    repeat (7) step();                                   // edge 10
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL full_held got %0h want 0", job_ready); end
    step();                                              // edge 11
    checks++; if (done_id !== 4'd1 || done_lane !== 2'd0 || done_valid !== 1'b1) begin
      errors++; $display("FAIL full_first got v%0h id%0h lane%0h want v1 id1 lane0", done_valid, done_id, done_lane); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %0h want 1", job_ready); end
    step();                                              // edge 12: fifth job taken
    job_valid = 1'b0;
    checks++; if (busy !== 4'b1101) begin errors++; $display("FAIL full_fifth_busy got %0h want d", busy); end
    checks++; if (done_id !== 4'd2 || done_lane !== 2'd1) begin
      errors++; $display("FAIL full_second got id%0h lane%0h want id2 lane1", done_id, done_lane); end
    step();                                              // edge 13
    checks++; if (done_id !== 4'd3 || done_lane !== 2'd2) begin
      errors++; $display("FAIL full_third got id%0h lane%0h want id3 lane2", done_id, done_lane); end
    step();                                              // edge 14
    checks++; if (done_id !== 4'd4 || done_lane !== 2'd3) begin
      errors++; $display("FAIL full_fourth got id%0h lane%0h want id4 lane3", done_id, done_lane); end
    step();                                              // edge 15
    checks++; if (done_id !== 4'd9 || done_lane !== 2'd0 || done_valid !== 1'b1) begin
      errors++; $display("FAIL full_fifth got v%0h id%0h lane%0h want v1 id9 lane0", done_valid, done_id, done_lane); end
    step();                                              // edge 16
    checks++; if (all_idle !== 1'b1) begin errors++; $display("FAIL full_drained got %0h want 1", all_idle); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    done_ready = 1'b0;
    for (int i = 0; i < 4; i++) send('{id: 4'(10 + i), cycles: 8'd3});  // edges 0..3
    step();                                              // edge 4
    checks++; if (done_valid !== 1'b1 || done_id !== 4'd10 || done_lane !== 2'd0) begin
      errors++; $display("FAIL bp_load got v%0h id%0h lane%0h want v1 ida lane0", done_valid, done_id, done_lane); end
    repeat (6) step();                                   // edge 10
    checks++; if (done_valid !== 1'b1 || done_id !== 4'd10 || done_lane !== 2'd0) begin
      errors++; $display("FAIL bp_frozen got v%0h id%0h lane%0h want v1 ida lane0", done_valid, done_id, done_lane); end
    checks++; if (busy !== 4'b1110) begin errors++; $display("FAIL bp_busy got %0h want e", busy); end
    done_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (done_valid !== 1'b1 || done_id !== 4'(10 + i) || done_lane !== 2'(i)) begin
        errors++; $display("FAIL bp_drain%0d got v%0h id%0h lane%0h want v1 id%0h lane%0h",
                           i, done_valid, done_id, done_lane, 10 + i, i); end
    end
    step();                                              // edge 14
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0h want 0", done_valid); end
    // Pointer is back at 0: two lanes finishing together grant lane 0 first.
    send('{id: 4'd6, cycles: 8'd2});
    send('{id: 4'd7, cycles: 8'd1});
    step();
    step();
    checks++; if (done_id !== 4'd6 || done_lane !== 2'd0) begin
      errors++; $display("FAIL rr_first got id%0h lane%0h want id6 lane0", done_id, done_lane); end
    step();
    checks++; if (done_id !== 4'd7 || done_lane !== 2'd1) begin
      errors++; $display("FAIL rr_second got id%0h lane%0h want id7 lane1", done_id, done_lane); end
    step();
  endtask

  task automatic test_reset_mid();
    bit late;
    do_reset();
    done_ready = 1'b0;
    for (int i = 0; i < 4; i++) send('{id: 4'(1 + i), cycles: 8'd3});
    step();                                              // edge 4: lane 0 popped into output
    send('{id: 4'd5, cycles: 8'd20});                    // edge 5: refills lane 0
    checks++; if (busy !== 4'hF || done_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got busy%0h v%0h want busyf v1", busy, done_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (done_valid !== 1'b0 || busy !== 4'h0 || all_idle !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v%0h busy%0h idle%0h want v0 busy0 idle1", done_valid, busy, all_idle); end
    done_ready = 1'b1;
    late = 1'b0;
    repeat (30) begin
      step();
      if (done_valid !== 1'b0) late = 1'b1;
    end
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL mid_late got %0h want 0", late); end
  endtask

`ifdef ARYA_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    done_ready = 1'b0;
    for (int i = 0; i < 4; i++) send('{id: 4'(i), cycles: 8'd1});
    repeat (4) step();
    checks++; if (jobs_done_cnt !== 32'd0) begin errors++; $display("FAIL perf_stall got %0d want 0", jobs_done_cnt); end
    done_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 3; i++) send('{id: 4'(i + 4), cycles: 8'd2});
    repeat (10) step();
    checks++; if (jobs_done_cnt !== 32'd7) begin errors++; $display("FAIL perf_count got %0d want 7", jobs_done_cnt); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    job_valid  = 1'b0;
    job_id     = '0;
    job_cycles = '0;
    done_ready = 1'b0;
    test_reset();
    test_single();
    test_zero_cycles();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef ARYA_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_job_engine

`default_nettype wire
